// File: rtl/recovery_transmitter_pkg.sv
// Shared types and constants for the recovery-command TX framer and its PEC helper.
package recovery_transmitter_pkg;

  localparam int unsigned LenW  = 16;
  localparam int unsigned ByteW = 8;

  // CRC-8 polynomial x^8 + x^2 + x + 1, used for SMBus-style PEC.
  localparam logic [ByteW-1:0] RecoveryPecPoly = 8'h07;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
    StPad   = 3'd4,
    StPec   = 3'd5,
    StFlush = 3'd6
  } rec_tx_state_e;

endpackage

// File: rtl/recovery_pec.sv
// Single-byte CRC-8 step (MSB first, no reflection, no final XOR); shared with the RX PEC check.
module recovery_pec
  import recovery_transmitter_pkg::*;
(
  input  logic [ByteW-1:0] crc_i,
  input  logic [ByteW-1:0] byte_i,
  output logic [ByteW-1:0] crc_o
);

  // Fold the byte into the register, then shift out eight bits through the polynomial.
  always_comb begin
    crc_o = crc_i ^ byte_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[7]) begin
        crc_o = {crc_o[6:0], 1'b0} ^ RecoveryPecPoly;
      end else begin
        crc_o = {crc_o[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/recovery_transmitter.sv
// Frames recovery read responses as LEN_L, LEN_H, payload, optional PEC into the TTI TX queue.
module recovery_transmitter
  import recovery_transmitter_pkg::*;
#(
  parameter bit               PecEnable = 1'b1,
  parameter logic [ByteW-1:0] PecInit   = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [LenW-1:0]  res_len_i,
  input  logic             res_dvalid_i,
  output logic             res_dready_o,
  input  logic [ByteW-1:0] res_data_i,
  input  logic             res_dlast_i,
  input  logic             pec_seed_valid_i,
  input  logic [ByteW-1:0] pec_seed_i,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [ByteW-1:0] tx_data_o,
  output logic             tx_last_o,
  input  logic             tx_abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             len_err_o
);

  rec_tx_state_e    state_q;
  logic [LenW-1:0]  len_q;
  logic [LenW-1:0]  cnt_q;
  logic [ByteW-1:0] crc_q;
  logic [ByteW-1:0] crc_d;
  logic             pending_q;   // upstream has not yet handed over its last byte
  logic             done_q;
  logic             len_err_q;

  logic tx_hs;
  logic cnt_one;
  logic last_hs;
  logic abort_act;

  assign tx_hs     = tx_valid_o & tx_ready_i;
  assign cnt_one   = (cnt_q == LenW'(1));
  assign last_hs   = (state_q == StData) & tx_hs & res_dlast_i;
  assign abort_act = tx_abort_i & (state_q != StIdle) & (state_q != StFlush);

  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign len_err_o = len_err_q;

  // CRC advances over whatever byte is currently offered on the TX side.
  recovery_pec u_pec (
    .crc_i  (crc_q),
    .byte_i (tx_data_o),
    .crc_o  (crc_d)
  );

  // Output decode from state; Data state passes the upstream byte straight through.
  always_comb begin
    res_ready_o  = 1'b0;
    res_dready_o = 1'b0;
    tx_valid_o   = 1'b0;
    tx_data_o    = '0;
    tx_last_o    = 1'b0;
    case (state_q)
      StIdle: res_ready_o = 1'b1;
      StLenLo: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[7:0];
      end
      StLenHi: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[15:8];
        tx_last_o  = (len_q == '0) && !PecEnable;
      end
      StData: begin
        tx_valid_o   = res_dvalid_i;
        tx_data_o    = res_data_i;
        res_dready_o = tx_ready_i;
        tx_last_o    = cnt_one && !PecEnable;
      end
      StPad: begin
        tx_valid_o = 1'b1;
        tx_last_o  = cnt_one && !PecEnable;
      end
      StPec: begin
        tx_valid_o = 1'b1;
        tx_data_o  = crc_q;
        tx_last_o  = 1'b1;
      end
      StFlush: res_dready_o = 1'b1;
      default: ;
    endcase
  end

  // Frame sequencing, length tracking, CRC accumulation and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (abort_act) begin
        // An abort beats any handshake, but a last byte taken this cycle is still gone upstream.
        state_q <= (pending_q && !last_hs) ? StFlush : StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (res_valid_i) begin
              len_q     <= res_len_i;
              cnt_q     <= res_len_i;
              crc_q     <= pec_seed_valid_i ? pec_seed_i : PecInit;
              pending_q <= (res_len_i != '0);
              state_q   <= StLenLo;
            end
          end
          StLenLo: begin
            if (tx_hs) begin
              crc_q   <= crc_d;
              state_q <= StLenHi;
            end
          end
          StLenHi: begin
            if (tx_hs) begin
              crc_q <= crc_d;
              if (len_q != '0) begin
                state_q <= StData;
              end else if (PecEnable) begin
                state_q <= StPec;
              end else begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StData: begin
            if (tx_hs) begin
              crc_q <= crc_d;
              cnt_q <= cnt_q - LenW'(1);
              if (res_dlast_i) begin
                pending_q <= 1'b0;
              end
              if (cnt_one) begin
                // Declared length reached; a missing last marker means upstream overran.
                len_err_q <= !res_dlast_i;
                if (PecEnable) begin
                  state_q <= StPec;
                end else begin
                  done_q  <= 1'b1;
                  state_q <= res_dlast_i ? StIdle : StFlush;
                end
              end else if (res_dlast_i) begin
                len_err_q <= 1'b1;
                state_q   <= StPad;
              end
            end
          end
          StPad: begin
            if (tx_hs) begin
              crc_q <= crc_d;
              cnt_q <= cnt_q - LenW'(1);
              if (cnt_one) begin
                if (PecEnable) begin
                  state_q <= StPec;
                end else begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
                end
              end
            end
          end
          StPec: begin
            if (tx_hs) begin
              done_q  <= 1'b1;
              state_q <= pending_q ? StFlush : StIdle;
            end
          end
          StFlush: begin
            if (res_dvalid_i && res_dlast_i) begin
              pending_q <= 1'b0;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recovery_transmitter.sv
// Self-checking bench for recovery_transmitter: table vectors, corner sequences, random frames.
module tb_recovery_transmitter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [15:0] res_len_i;
  logic        res_dvalid_i;
  logic        res_dready_o;
  logic [7:0]  res_data_i;
  logic        res_dlast_i;
  logic        pec_seed_valid_i;
  logic [7:0]  pec_seed_i;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  tx_data_o;
  logic        tx_last_o;
  logic        tx_abort_i;
  logic        busy_o;
  logic        done_o;
  logic        len_err_o;

  logic [7:0]  pc_crc;
  logic [7:0]  pc_byte;
  logic [7:0]  pc_out;

  always #5 clk_i = ~clk_i;

  recovery_transmitter #(
    .PecEnable (1'b1),
    .PecInit   (8'h00)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .res_valid_i      (res_valid_i),
    .res_ready_o      (res_ready_o),
    .res_len_i        (res_len_i),
    .res_dvalid_i     (res_dvalid_i),
    .res_dready_o     (res_dready_o),
    .res_data_i       (res_data_i),
    .res_dlast_i      (res_dlast_i),
    .pec_seed_valid_i (pec_seed_valid_i),
    .pec_seed_i       (pec_seed_i),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .tx_data_o        (tx_data_o),
    .tx_last_o        (tx_last_o),
    .tx_abort_i       (tx_abort_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .len_err_o        (len_err_o)
  );

  recovery_pec u_pec_ref (
    .crc_i  (pc_crc),
    .byte_i (pc_byte),
    .crc_o  (pc_out)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  bit         outl_q[$];
  int         done_cnt, err_cnt, idx, dready_hi, txv_after;
  bit         finished;

  typedef struct {
    int         len;
    int         n;
    bit         sv;
    logic [7:0] seed;
    logic [7:0] base;
    logic [7:0] step;
    int         exp_err;
    bit         chk_pec;
    logic [7:0] exp_pec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Bit-serial LFSR form of CRC-8/0x07: feedback is MSB xor next data bit.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[7] ^ d[k];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    res_valid_i      = 1'b0;
    res_len_i        = '0;
    res_dvalid_i     = 1'b0;
    res_data_i       = '0;
    res_dlast_i      = 1'b0;
    pec_seed_valid_i = 1'b0;
    pec_seed_i       = '0;
    tx_ready_i       = 1'b0;
    tx_abort_i       = 1'b0;
  endtask

  // Drives one frame: header, upstream bytes from pay_q, random back-pressure, optional abort.
  task automatic run_frame(input int len, input int n, input bit sv, input logic [7:0] seed,
                           input int rdy_pct, input int dv_pct, input int abort_at);
    int cyc;
    bit hdr_done, seen_busy, aborted, abort_now;
    out_q.delete();
    outl_q.delete();
    done_cnt = 0; err_cnt = 0; idx = 0; dready_hi = 0; txv_after = 0;
    finished = 0; hdr_done = 0; seen_busy = 0; aborted = 0; cyc = 0;
    while (!finished && cyc < 4000) begin
      @(negedge clk_i);
      res_valid_i      = !hdr_done;
      res_len_i        = 16'(len);
      pec_seed_valid_i = sv;
      pec_seed_i       = seed;
      tx_ready_i       = ($urandom_range(99) < rdy_pct);
      res_dvalid_i     = hdr_done && (idx < n) && ($urandom_range(99) < dv_pct);
      res_data_i       = (idx < n) ? pay_q[idx] : 8'h00;
      res_dlast_i      = (idx < n) && (idx == n - 1);
      abort_now        = (abort_at >= 0) && !aborted && hdr_done && (out_q.size() == abort_at);
      tx_abort_i       = abort_now;
      #1;
      if (aborted && tx_valid_o) txv_after++;
      if (hdr_done && res_dready_o && len == 0) dready_hi++;
      if (tx_valid_o && tx_ready_i) begin
        out_q.push_back(tx_data_o);
        outl_q.push_back(tx_last_o);
      end
      if (res_dvalid_i && res_dready_o) idx++;
      if (done_o) done_cnt++;
      if (len_err_o) err_cnt++;
      if (abort_now) aborted = 1;
      if (res_valid_i && res_ready_o) hdr_done = 1;
      else if (hdr_done && seen_busy && !busy_o) finished = 1;
      if (busy_o) seen_busy = 1;
      cyc++;
    end
    @(negedge clk_i);
    idle_inputs();
    check("frame_completes", 32'(finished), 32'd1);
  endtask

  // Expected wire stream from the frame rules: length, payload truncated/zero-padded to len, PEC.
  task automatic verify(input string tag, input int len, input int n, input bit sv,
                        input logic [7:0] seed, input int exp_err);
    logic [7:0] c;
    exp_q.delete();
    exp_q.push_back(8'(len));
    exp_q.push_back(8'(len >> 8));
    for (int i = 0; i < len; i++) exp_q.push_back((i < n) ? pay_q[i] : 8'h00);
    c = sv ? seed : 8'h00;
    foreach (exp_q[i]) c = ref_crc(c, exp_q[i]);
    exp_q.push_back(c);
    check({tag, "_nbytes"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(outl_q[i]), 32'(i == exp_q.size() - 1));
    end
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_len_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_drained"}, 32'(idx), 32'(n));
    if (len == 0) check({tag, "_dready_len0"}, 32'(dready_hi), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] c;
    string      s;
    int         len, n;
    bit         sv;
    logic [7:0] seed;

    vecs[0] = '{len: 1, n: 1, sv: 0, seed: 8'h00, base: 8'h01, step: 8'h00, exp_err: 0, chk_pec: 1, exp_pec: 8'h6C};
    vecs[1] = '{len: 0, n: 0, sv: 0, seed: 8'h00, base: 8'h00, step: 8'h00, exp_err: 0, chk_pec: 1, exp_pec: 8'h00};
    vecs[2] = '{len: 4, n: 2, sv: 0, seed: 8'h00, base: 8'hAA, step: 8'h11, exp_err: 1, chk_pec: 0, exp_pec: 8'h00};
    vecs[3] = '{len: 2, n: 3, sv: 0, seed: 8'h00, base: 8'h30, step: 8'h01, exp_err: 1, chk_pec: 0, exp_pec: 8'h00};
    vecs[4] = '{len: 5, n: 5, sv: 1, seed: 8'h5A, base: 8'h10, step: 8'h07, exp_err: 0, chk_pec: 0, exp_pec: 8'h00};
    vecs[5] = '{len: 3, n: 1, sv: 1, seed: 8'hC3, base: 8'hE0, step: 8'h00, exp_err: 1, chk_pec: 0, exp_pec: 8'h00};

    idle_inputs();
    pc_crc  = '0;
    pc_byte = '0;
    rst_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_tx_last", 32'(tx_last_o), 32'd0);
    check("rst_dready", 32'(res_dready_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_len_err", 32'(len_err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_res_ready", 32'(res_ready_o), 32'd1);

    // Standalone PEC over the classic check string.
    s = "123456789";
    c = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      pc_crc  = c;
      pc_byte = s[i];
      #1;
      c = pc_out;
    end
    check("pec_check_string", 32'(c), 32'hF4);

    foreach (vecs[v]) begin
      pay_q.delete();
      for (int i = 0; i < vecs[v].n; i++) pay_q.push_back(vecs[v].base + 8'(i) * vecs[v].step);
      run_frame(vecs[v].len, vecs[v].n, vecs[v].sv, vecs[v].seed, 100, 100, -1);
      verify($sformatf("vec%0d", v), vecs[v].len, vecs[v].n, vecs[v].sv, vecs[v].seed, vecs[v].exp_err);
      if (vecs[v].chk_pec && out_q.size() > 0)
        check($sformatf("vec%0d_pec_const", v), 32'(out_q[out_q.size() - 1]), 32'(vecs[v].exp_pec));
      repeat (2) @(negedge clk_i);
    end

    // Reset in the middle of a frame drops it silently.
    @(negedge clk_i);
    res_valid_i = 1'b1; res_len_i = 16'd6;
    @(negedge clk_i);
    res_valid_i = 1'b0; tx_ready_i = 1'b1; res_dvalid_i = 1'b1; res_data_i = 8'h55;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1; res_dvalid_i = 1'b0; tx_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("midrst_res_ready", 32'(res_ready_o), 32'd1);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk_i);
      #1;
      if (done_o) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // Abort in Data with three bytes still owed, under random back-pressure.
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h80 + i));
    run_frame(8, 8, 0, 8'h00, 60, 100, 7);
    check("abort_data_no_done", 32'(done_cnt), 32'd0);
    check("abort_data_no_len_err", 32'(err_cnt), 32'd0);
    check("abort_data_tx_quiet", 32'(txv_after), 32'd0);
    check("abort_data_drained", 32'(idx), 32'd8);
    repeat (2) @(negedge clk_i);

    // Abort while the length low byte is still on offer.
    pay_q.delete();
    for (int i = 0; i < 3; i++) pay_q.push_back(8'(8'h40 + i));
    run_frame(3, 3, 0, 8'h00, 0, 70, 0);
    check("abort_lenlo_no_done", 32'(done_cnt), 32'd0);
    check("abort_lenlo_tx_quiet", 32'(txv_after), 32'd0);
    check("abort_lenlo_drained", 32'(idx), 32'd3);
    repeat (2) @(negedge clk_i);

    // Randomised frames against the reference stream model.
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(0, 20));
      if (len == 0) n = 0;
      else if ($urandom_range(1) == 0) n = len;
      else n = int'($urandom_range(1, len + 3));
      sv   = bit'($urandom_range(1));
      seed = 8'($urandom);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      run_frame(len, n, sv, seed, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), -1);
      verify($sformatf("rnd%0d", f), len, n, sv, seed, (n != len) ? 1 : 0);
      repeat (int'($urandom_range(1, 3))) @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
